layer_seq: RTL and testbench

LAYER_SEQ -- requirements
Module: layer_seq

---
 rtl/cnn_pkg.sv | 6 +
 rtl/global.svh | 7 +
 rtl/ofmap_fifo.sv | 41 ++++
 rtl/layer_seq.sv | 172 +++++++++++++++++
 tb/tb_layer_seq.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: sequencer state encoding and timing constants shared by the CNN blocks.
package cnn_pkg;
   typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_I, GAP, RUN, DRAIN, FIN} state_t;
   localparam int unsigned GAP_LEN = 2;
   localparam int unsigned GAP_W = 2;
endpackage

// File: rtl/global.svh
// global.svh: project-wide datapath widths shared by the CNN accelerator blocks.
`ifndef GLOBAL_SVH
`define GLOBAL_SVH
`define DATA_WIDTH 8
`define SPAD_DATA_WIDTH 16
`define ADDR_WIDTH 8
`endif

// File: rtl/ofmap_fifo.sv
// ofmap_fifo: in-order result buffer; a push into a full buffer only lands
// when the same cycle also pops, otherwise the word is dropped and flagged.
module ofmap_fifo #(
   parameter int OUT_W = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic             i_clk,
   input  logic             i_nrst,
   input  logic             i_push,
   input  logic [OUT_W-1:0] i_data,
   input  logic             i_pop,
   output logic [OUT_W-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_drop
);
   localparam int AW = $clog2(FIFO_DEPTH);
   logic [AW:0] wr_q, wr_d, rd_q, rd_d;
   logic [OUT_W-1:0] mem_q [FIFO_DEPTH];
   logic push_ok, pop_ok;
   assign o_empty = wr_q == rd_q;
   assign o_full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign pop_ok = i_pop && !o_empty;
   assign push_ok = i_push && (!o_full || pop_ok);
   assign o_drop = i_push && !push_ok;
   assign o_data = o_empty ? '0 : mem_q[rd_q[AW-1:0]];
   always_comb begin
      wr_d = wr_q + {{AW{1'b0}}, push_ok};
      rd_d = rd_q + {{AW{1'b0}}, pop_ok};
   end
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end
   always_ff @(posedge i_clk) if (push_ok) mem_q[wr_q[AW-1:0]] <= i_data;
endmodule

// File: rtl/layer_seq.sv
// layer_seq: loads weight/ifmap scratchpads from a stream, runs the accelerator and
// buffers its ofmap results. Define LAYER_SEQ_CYCLE_CNT_EN to add the o_cycles run counter.
`include "global.svh"
module layer_seq import cnn_pkg::*; #(
   parameter int DATA_W = `SPAD_DATA_WIDTH,
   parameter int ADDR_W = `ADDR_WIDTH,
   parameter int OUT_W = 2*`DATA_WIDTH,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              i_clk,
   input  logic              i_nrst,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_w_count,
   input  logic [ADDR_W-1:0] i_i_count,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   output logic              o_overflow,
`ifdef LAYER_SEQ_CYCLE_CNT_EN
   output logic [31:0]       o_cycles,
`endif
   input  logic [DATA_W-1:0] i_s_data,
   input  logic              i_s_valid,
   output logic              o_s_ready,
   output logic              o_write_en,
   output logic [ADDR_W-1:0] o_write_addr,
   output logic              o_spad_select,
   output logic [DATA_W-1:0] o_data_in,
   output logic              o_route_en,
   output logic [ADDR_W-1:0] o_i_addr_end,
   input  logic              i_acc_done,
   input  logic [OUT_W-1:0]  i_ofmap,
   input  logic              i_ofmap_valid,
   output logic [OUT_W-1:0]  o_m_data,
   output logic              o_m_valid,
   input  logic              i_m_ready
);
   state_t state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d, w_cnt_q, w_cnt_d, i_cnt_q, i_cnt_d;
   logic [ADDR_W-1:0] write_addr_q, write_addr_d, i_addr_end_q, i_addr_end_d;
   logic [DATA_W-1:0] data_in_q, data_in_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic write_en_q, write_en_d, spad_sel_q, spad_sel_d, route_en_q, route_en_d;
   logic busy_q, busy_d, done_q, done_d, err_q, err_d, overflow_q, overflow_d;
   logic s_ready_q, s_ready_d;
   logic fifo_full, fifo_empty, fifo_drop, xfer;
`ifdef LAYER_SEQ_CYCLE_CNT_EN
   logic [31:0] cycles_q, cycles_d;
   assign o_cycles = cycles_q;
`endif
   ofmap_fifo #(.OUT_W(OUT_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk(i_clk), .i_nrst(i_nrst), .i_push(i_ofmap_valid), .i_data(i_ofmap),
      .i_pop(o_m_valid && i_m_ready), .o_data(o_m_data), .o_full(fifo_full),
      .o_empty(fifo_empty), .o_drop(fifo_drop)
   );
   assign o_m_valid = !fifo_empty;
   assign xfer = i_s_valid && s_ready_q;
   always_comb begin
      state_d = state_q;
      addr_d = addr_q;
      w_cnt_d = w_cnt_q;
      i_cnt_d = i_cnt_q;
      write_addr_d = write_addr_q;
      i_addr_end_d = i_addr_end_q;
      data_in_d = data_in_q;
      spad_sel_d = spad_sel_q;
      gap_d = gap_q;
      overflow_d = overflow_q;
      write_en_d = 1'b0;
      err_d = 1'b0;
`ifdef LAYER_SEQ_CYCLE_CNT_EN
      cycles_d = (state_q == RUN && cycles_q != '1) ? cycles_q + 32'd1 : cycles_q;
`endif
      case (state_q)
         IDLE: if (i_start) begin
            if (i_i_count == '0) err_d = 1'b1;
            else begin
               state_d = (i_w_count == '0) ? LOAD_I : LOAD_W;
               w_cnt_d = i_w_count;
               i_cnt_d = i_i_count;
               addr_d = '0;
               overflow_d = 1'b0;
`ifdef LAYER_SEQ_CYCLE_CNT_EN
               cycles_d = '0;
`endif
            end
         end
         LOAD_W, LOAD_I: if (xfer) begin
            write_en_d = 1'b1;
            write_addr_d = addr_q;
            data_in_d = i_s_data;
            spad_sel_d = state_q == LOAD_I;
            addr_d = addr_q + 1'b1;
            if (state_q == LOAD_W && addr_q == w_cnt_q - 1'b1) begin
               state_d = LOAD_I;
               addr_d = '0;
            end else if (state_q == LOAD_I && addr_q == i_cnt_q - 1'b1) begin
               state_d = GAP;
               gap_d = '0;
               i_addr_end_d = i_cnt_q - 1'b1;
            end
         end
         GAP: begin
            gap_d = gap_q + 1'b1;
            if (gap_q == GAP_W'(GAP_LEN - 1)) state_d = RUN;
         end
         RUN: if (i_acc_done) state_d = DRAIN;
         DRAIN: if (fifo_empty) state_d = FIN;
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (fifo_drop) overflow_d = 1'b1;
      busy_d = state_d != IDLE;
      s_ready_d = state_d == LOAD_W || state_d == LOAD_I;
      route_en_d = state_d == RUN;
      done_d = state_d == FIN;
   end
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state_q <= IDLE;
         addr_q <= '0;
         w_cnt_q <= '0;
         i_cnt_q <= '0;
         write_addr_q <= '0;
         i_addr_end_q <= '0;
         data_in_q <= '0;
         spad_sel_q <= 1'b0;
         gap_q <= '0;
         write_en_q <= 1'b0;
         route_en_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q <= 1'b0;
         overflow_q <= 1'b0;
         s_ready_q <= 1'b0;
`ifdef LAYER_SEQ_CYCLE_CNT_EN
         cycles_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q <= addr_d;
         w_cnt_q <= w_cnt_d;
         i_cnt_q <= i_cnt_d;
         write_addr_q <= write_addr_d;
         i_addr_end_q <= i_addr_end_d;
         data_in_q <= data_in_d;
         spad_sel_q <= spad_sel_d;
         gap_q <= gap_d;
         write_en_q <= write_en_d;
         route_en_q <= route_en_d;
         busy_q <= busy_d;
         done_q <= done_d;
         err_q <= err_d;
         overflow_q <= overflow_d;
         s_ready_q <= s_ready_d;
`ifdef LAYER_SEQ_CYCLE_CNT_EN
         cycles_q <= cycles_d;
`endif
      end
   end
   assign o_busy = busy_q;
   assign o_done = done_q;
   assign o_err = err_q;
   assign o_overflow = overflow_q;
   assign o_s_ready = s_ready_q;
   assign o_write_en = write_en_q;
   assign o_write_addr = write_addr_q;
   assign o_spad_select = spad_sel_q;
   assign o_data_in = data_in_q;
   assign o_route_en = route_en_q;
   assign o_i_addr_end = i_addr_end_q;
endmodule

// File: tb/tb_layer_seq.sv
// tb_layer_seq: directed scenarios for layer_seq with hand-computed expectations.
module tb_layer_seq;
   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;
   logic start = 1'b0, s_valid = 1'b0, acc_done = 1'b0, ofmap_valid = 1'b0, m_ready = 1'b0;
   logic [7:0] w_count = '0, i_count = '0;
   logic [15:0] s_data = '0, ofmap = '0;
   logic busy, done, err, overflow, s_ready, write_en, spad_select, route_en, m_valid;
   logic [7:0] write_addr, i_addr_end;
   logic [15:0] data_in, m_data;
`ifdef LAYER_SEQ_CYCLE_CNT_EN
   logic [31:0] cycles;
`endif
   layer_seq dut (
      .i_clk(clk), .i_nrst(rst_n), .i_start(start), .i_w_count(w_count), .i_i_count(i_count),
      .o_busy(busy), .o_done(done), .o_err(err), .o_overflow(overflow),
`ifdef LAYER_SEQ_CYCLE_CNT_EN
      .o_cycles(cycles),
`endif
      .i_s_data(s_data), .i_s_valid(s_valid), .o_s_ready(s_ready),
      .o_write_en(write_en), .o_write_addr(write_addr), .o_spad_select(spad_select),
      .o_data_in(data_in), .o_route_en(route_en), .o_i_addr_end(i_addr_end),
      .i_acc_done(acc_done), .i_ofmap(ofmap), .i_ofmap_valid(ofmap_valid),
      .o_m_data(m_data), .o_m_valid(m_valid), .i_m_ready(m_ready)
   );

   int vecs = 0, errs = 0;
   logic [24:0] wrec[$];
   int wcyc[$];
   int route_cyc;
   logic [15:0] pd[$];
   int done_n, done_c, last_pop;
   logic route_after;

   // Starts a layer and streams words; records every scratchpad write as {select, addr, data}.
   task automatic do_load(input logic [7:0] wc, input logic [7:0] ic, input logic [15:0] base,
                          input int limit, input int ncyc);
      int sent = 0;
      wrec.delete();
      wcyc.delete();
      route_cyc = -1;
      @(negedge clk);
      start = 1'b1; w_count = wc; i_count = ic;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         if (write_en) begin
            wrec.push_back({spad_select, write_addr, data_in});
            wcyc.push_back(c);
         end
         if (route_en && route_cyc < 0) route_cyc = c;
         s_valid = sent < limit;
         s_data = base + 16'(sent);
         if (s_ready && s_valid) sent++;
         @(negedge clk);
      end
      s_valid = 1'b0;
   endtask

   task automatic finish_layer();
      pd.delete();
      done_n = 0; done_c = -1; last_pop = -1; route_after = 1'bx;
      acc_done = 1'b1; m_ready = 1'b1;
      for (int c = 0; c < 30; c++) begin
         if (c == 1) route_after = route_en;
         if (done) begin
            done_n++;
            if (done_c < 0) done_c = c;
         end
         if (m_valid) begin
            pd.push_back(m_data);
            last_pop = c;
         end
         @(negedge clk);
         acc_done = 1'b0;
      end
      m_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge clk);
      #2;
      vecs++;
      if ({busy, s_ready, write_en, route_en, done, err, overflow, m_valid} !== 8'b0) begin
         errs++;
         $display("FAIL reset_flags got %b want 00000000", {busy, s_ready, write_en, route_en, done, err, overflow, m_valid});
      end
      vecs++;
      if ({write_addr, i_addr_end, data_in, m_data} !== 48'b0) begin
         errs++;
         $display("FAIL reset_buses got %h want 0", {write_addr, i_addr_end, data_in, m_data});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vecs++;
      if (busy !== 1'b0 || s_ready !== 1'b0) begin
         errs++;
         $display("FAIL idle_after_reset busy=%b ready=%b want 0 0", busy, s_ready);
      end
   endtask

   task automatic test_load();
      logic [7:0] ea [8] = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
      logic [24:0] exp;
      do_load(8'd3, 8'd5, 16'hA000, 100, 20);
      vecs++;
      if (wrec.size() != 8) begin
         errs++;
         $display("FAIL load_write_count got %0d want 8", wrec.size());
      end
      for (int k = 0; k < 8 && k < wrec.size(); k++) begin
         exp = {k >= 3, ea[k], 16'hA000 + 16'(k)};
         vecs++;
         if (wrec[k] !== exp) begin
            errs++;
            $display("FAIL load_write[%0d] got %h want %h", k, wrec[k], exp);
         end
      end
      vecs++;
      if (i_addr_end !== 8'd4) begin
         errs++;
         $display("FAIL i_addr_end got %0d want 4", i_addr_end);
      end
      vecs++;
      if (wcyc.size() == 0 || route_cyc - wcyc[wcyc.size()-1] != 2) begin
         errs++;
         $display("FAIL route_rise_delay got route=%0d writes=%0d want 2 after last write", route_cyc, wcyc.size());
      end
      vecs++;
      if (busy !== 1'b1 || route_en !== 1'b1) begin
         errs++;
         $display("FAIL run_state busy=%b route=%b want 1 1", busy, route_en);
      end
      finish_layer();
      vecs++;
      if (route_after !== 1'b0) begin
         errs++;
         $display("FAIL route_drop got %b want 0", route_after);
      end
      vecs++;
      if (done_n != 1 || pd.size() != 0 || busy !== 1'b0) begin
         errs++;
         $display("FAIL load_finish done=%0d pops=%0d busy=%b want 1 0 0", done_n, pd.size(), busy);
      end
   endtask

   task automatic test_no_weights();
      do_load(8'd0, 8'd2, 16'hB000, 100, 12);
      vecs++;
      if (wrec.size() != 2) begin
         errs++;
         $display("FAIL nw_write_count got %0d want 2", wrec.size());
      end
      for (int k = 0; k < 2 && k < wrec.size(); k++) begin
         vecs++;
         if (wrec[k] !== {1'b1, 8'(k), 16'hB000 + 16'(k)}) begin
            errs++;
            $display("FAIL nw_write[%0d] got %h want %h", k, wrec[k], {1'b1, 8'(k), 16'hB000 + 16'(k)});
         end
      end
      vecs++;
      if (route_cyc < 0) begin
         errs++;
         $display("FAIL nw_run got route_cyc=%0d want RUN reached", route_cyc);
      end
      finish_layer();
      vecs++;
      if (done_n != 1) begin
         errs++;
         $display("FAIL nw_done got %0d want 1", done_n);
      end
   endtask

   task automatic test_overflow();
      do_load(8'd0, 8'd1, 16'hC000, 100, 6);
      for (int k = 0; k < 10; k++) begin
         ofmap = 16'h0100 + 16'(k);
         ofmap_valid = 1'b1;
         @(negedge clk);
      end
      ofmap_valid = 1'b0;
      vecs++;
      if (overflow !== 1'b1 || m_valid !== 1'b1 || m_data !== 16'h0100) begin
         errs++;
         $display("FAIL ovf_flag ovf=%b valid=%b head=%h want 1 1 0100", overflow, m_valid, m_data);
      end
      finish_layer();
      vecs++;
      if (pd.size() != 8) begin
         errs++;
         $display("FAIL ovf_count got %0d want 8", pd.size());
      end
      for (int k = 0; k < 8 && k < pd.size(); k++) begin
         vecs++;
         if (pd[k] !== 16'h0100 + 16'(k)) begin
            errs++;
            $display("FAIL ovf_word[%0d] got %h want %h", k, pd[k], 16'h0100 + 16'(k));
         end
      end
      vecs++;
      if (done_n != 1 || done_c != last_pop + 2) begin
         errs++;
         $display("FAIL ovf_done count=%0d at=%0d want 1 at %0d", done_n, done_c, last_pop + 2);
      end
      vecs++;
      if (overflow !== 1'b1) begin
         errs++;
         $display("FAIL ovf_sticky got %b want 1", overflow);
      end
   endtask

   task automatic test_full_pushpop();
      do_load(8'd0, 8'd1, 16'hD000, 100, 6);
      vecs++;
      if (overflow !== 1'b0) begin
         errs++;
         $display("FAIL ovf_clear got %b want 0", overflow);
      end
      for (int k = 0; k < 8; k++) begin
         ofmap = 16'h0200 + 16'(k);
         ofmap_valid = 1'b1;
         @(negedge clk);
      end
      ofmap = 16'h0208;
      m_ready = 1'b1;
      @(negedge clk);
      ofmap_valid = 1'b0;
      m_ready = 1'b0;
      vecs++;
      if (overflow !== 1'b0) begin
         errs++;
         $display("FAIL full_pushpop_ovf got %b want 0", overflow);
      end
      finish_layer();
      vecs++;
      if (pd.size() != 8) begin
         errs++;
         $display("FAIL full_pushpop_count got %0d want 8", pd.size());
      end
      for (int k = 0; k < 8 && k < pd.size(); k++) begin
         vecs++;
         if (pd[k] !== 16'h0201 + 16'(k)) begin
            errs++;
            $display("FAIL full_pushpop_word[%0d] got %h want %h", k, pd[k], 16'h0201 + 16'(k));
         end
      end
   endtask

   task automatic test_err();
      @(negedge clk);
      start = 1'b1; w_count = 8'd3; i_count = 8'd0;
      @(negedge clk);
      start = 1'b0;
      vecs++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         errs++;
         $display("FAIL err_pulse err=%b busy=%b want 1 0", err, busy);
      end
      @(negedge clk);
      vecs++;
      if (err !== 1'b0 || busy !== 1'b0) begin
         errs++;
         $display("FAIL err_end err=%b busy=%b want 0 0", err, busy);
      end
      do_load(8'd0, 8'd1, 16'h5000, 100, 6);
      start = 1'b1; w_count = 8'd2; i_count = 8'd3;
      @(negedge clk);
      start = 1'b0;
      vecs++;
      if (err !== 1'b0 || s_ready !== 1'b0 || route_en !== 1'b1) begin
         errs++;
         $display("FAIL start_in_run err=%b ready=%b route=%b want 0 0 1", err, s_ready, route_en);
      end
      finish_layer();
      vecs++;
      if (done_n != 1) begin
         errs++;
         $display("FAIL err_run_done got %0d want 1", done_n);
      end
   endtask

   task automatic test_reset_mid();
      ofmap = 16'h0777;
      ofmap_valid = 1'b1;
      do_load(8'd1, 8'd4, 16'hE000, 3, 3);
      vecs++;
      if ({write_en, spad_select, write_addr, data_in} !== {1'b1, 1'b1, 8'd1, 16'hE002} || m_valid !== 1'b1) begin
         errs++;
         $display("FAIL mid_load_write got %h valid=%b want %h 1", {write_en, spad_select, write_addr, data_in}, m_valid, {1'b1, 1'b1, 8'd1, 16'hE002});
      end
      ofmap_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      vecs++;
      if ({write_en, busy, m_valid, s_ready} !== 4'b0) begin
         errs++;
         $display("FAIL async_reset got we/busy/valid/ready=%b want 0000", {write_en, busy, m_valid, s_ready});
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_load(8'd0, 8'd2, 16'hF000, 100, 10);
      vecs++;
      if (wrec.size() != 2 || wrec[0] !== {1'b1, 8'd0, 16'hF000}) begin
         errs++;
         $display("FAIL reload writes=%0d first=%h want 2 %h", wrec.size(), wrec.size() ? wrec[0] : 25'h0, {1'b1, 8'd0, 16'hF000});
      end
      finish_layer();
      vecs++;
      if (done_n != 1 || busy !== 1'b0) begin
         errs++;
         $display("FAIL reload_done done=%0d busy=%b want 1 0", done_n, busy);
      end
   endtask

`ifdef LAYER_SEQ_CYCLE_CNT_EN
   task automatic test_cycles();
      do_load(8'd0, 8'd1, 16'h6000, 100, 3);
      vecs++;
      if (route_en !== 1'b1 || cycles !== 32'd0) begin
         errs++;
         $display("FAIL cyc_start route=%b cycles=%0d want 1 0", route_en, cycles);
      end
      repeat (49) @(negedge clk);
      finish_layer();
      vecs++;
      if (cycles !== 32'd50) begin
         errs++;
         $display("FAIL cyc_count got %0d want 50", cycles);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_load();
      test_no_weights();
      test_overflow();
      test_full_pushpop();
      test_err();
      test_reset_mid();
`ifdef LAYER_SEQ_CYCLE_CNT_EN
      test_cycles();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
